// File: rtl/ysyx_22040386_arb_pkg.sv
// Shared types for the IFU/LSU data-memory arbiter.
//   ARB_ADDR_W / ARB_DATA_W : default address/data widths
//   arb_state_e             : sequencer states IDLE -> ISSUE -> WAIT -> RESP
//   arb_owner_e             : transaction owner (OWN_IF=0, OWN_LS=1)
//   other_owner()           : the requester that is not the given one
package ysyx_22040386_arb_pkg;

   localparam int unsigned ARB_ADDR_W = 64;
   localparam int unsigned ARB_DATA_W = 64;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } arb_state_e;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_LS = 1'b1
   } arb_owner_e;

   function automatic arb_owner_e other_owner(input arb_owner_e o);
      return (o == OWN_IF) ? OWN_LS : OWN_IF;
   endfunction

endpackage

// File: rtl/ysyx_22040386_arb_pick.sv
// Combinational grant selection between IFU and LSU.
// Build option: YSYX_22040386_ARB_RR_EN selects round-robin on ties
// (the requester not granted last wins); otherwise LSU wins every tie.
// Ports:
//   if_valid_i   : IFU request pending
//   ls_valid_i   : LSU request pending
//   last_owner_i : owner of the most recent grant
//   grant_c_o    : some request may be granted
//   owner_c_o    : which requester gets the grant
module ysyx_22040386_arb_pick
   import ysyx_22040386_arb_pkg::*;
(
   input  logic       if_valid_i,
   input  logic       ls_valid_i,
   input  arb_owner_e last_owner_i,
   output logic       grant_c_o,
   output arb_owner_e owner_c_o
);

`ifndef YSYX_22040386_ARB_RR_EN
   // Fixed priority ignores history.
   logic unused_last_owner;
   assign unused_last_owner = last_owner_i;
`endif

   // Grant decision
   always_comb begin
      grant_c_o = if_valid_i | ls_valid_i;
      owner_c_o = OWN_IF;
      if (if_valid_i && ls_valid_i) begin
`ifdef YSYX_22040386_ARB_RR_EN
         owner_c_o = other_owner(last_owner_i);
`else
         owner_c_o = OWN_LS;
`endif
      end else if (ls_valid_i) begin
         owner_c_o = OWN_LS;
      end
   end

endmodule

// File: rtl/ysyx_22040386_mem_arb.sv
// Arbiter/sequencer for the single data-memory port shared by IFU and LSU.
// One transaction at a time: accept (IDLE) -> issue with valid/ready (ISSUE)
// -> wait for response (WAIT) -> one-cycle response to the owner (RESP).
// Build option: YSYX_22040386_ARB_RR_EN (round-robin ties, see arb_pick).
// Ports:
//   i_ARB_clk, i_ARB_rst_n           : clock, async active-low reset
//   i_ARB_if_* / o_ARB_if_*          : IFU fetch request and response
//   i_ARB_ls_* / o_ARB_ls_*          : LSU load/store request and response
//   o_ARB_mem_* / i_ARB_mem_*        : memory-side request and response
// The *_ready outputs are combinational (decoded in IDLE); all others are flops.
module ysyx_22040386_mem_arb
   import ysyx_22040386_arb_pkg::*;
#(
   parameter int unsigned ADDR_W = ARB_ADDR_W,
   parameter int unsigned DATA_W = ARB_DATA_W
) (
   input  logic                  i_ARB_clk,
   input  logic                  i_ARB_rst_n,
   input  logic                  i_ARB_if_valid,
   input  logic [ADDR_W-1:0]     i_ARB_if_addr,
   output logic                  o_ARB_if_ready,
   output logic                  o_ARB_if_rvalid,
   output logic [DATA_W-1:0]     o_ARB_if_rdata,
   input  logic                  i_ARB_ls_valid,
   input  logic                  i_ARB_ls_wen,
   input  logic [ADDR_W-1:0]     i_ARB_ls_addr,
   input  logic [DATA_W-1:0]     i_ARB_ls_wdata,
   input  logic [DATA_W/8-1:0]   i_ARB_ls_wmask,
   output logic                  o_ARB_ls_ready,
   output logic                  o_ARB_ls_rvalid,
   output logic [DATA_W-1:0]     o_ARB_ls_rdata,
   output logic                  o_ARB_mem_valid,
   input  logic                  i_ARB_mem_ready,
   output logic                  o_ARB_mem_wen,
   output logic [ADDR_W-1:0]     o_ARB_mem_addr,
   output logic [DATA_W-1:0]     o_ARB_mem_wdata,
   output logic [DATA_W/8-1:0]   o_ARB_mem_wmask,
   input  logic                  i_ARB_mem_rvalid,
   input  logic [DATA_W-1:0]     i_ARB_mem_rdata
);

   localparam int unsigned MASK_W = DATA_W / 8;

   arb_state_e          state_q, state_d;
   arb_owner_e          owner_q, owner_d;
   arb_owner_e          last_q, last_d;
   logic                wen_q, wen_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [MASK_W-1:0]   wmask_q, wmask_d;
   logic                mem_valid_q, mem_valid_d;
   logic                if_rvalid_q, if_rvalid_d;
   logic                ls_rvalid_q, ls_rvalid_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;

   logic                pick_grant;
   arb_owner_e          pick_owner;
   logic                accept_c;

   ysyx_22040386_arb_pick u_pick (
      .if_valid_i   (i_ARB_if_valid),
      .ls_valid_i   (i_ARB_ls_valid),
      .last_owner_i (last_q),
      .grant_c_o    (pick_grant),
      .owner_c_o    (pick_owner)
   );

   // Acceptance handshake: only in IDLE, only to the picked owner.
   assign accept_c       = (state_q == IDLE) && pick_grant;
   assign o_ARB_if_ready = accept_c && (pick_owner == OWN_IF);
   assign o_ARB_ls_ready = accept_c && (pick_owner == OWN_LS);

   // Next-state and registered-output logic
   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      last_d      = last_q;
      wen_d       = wen_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      wmask_d     = wmask_q;
      mem_valid_d = mem_valid_q;
      if_rvalid_d = 1'b0;
      ls_rvalid_d = 1'b0;
      rdata_d     = rdata_q;

      case (state_q)
         IDLE: begin
            if (pick_grant) begin
               state_d     = ISSUE;
               owner_d     = pick_owner;
               last_d      = pick_owner;
               mem_valid_d = 1'b1;
               if (pick_owner == OWN_LS) begin
                  wen_d   = i_ARB_ls_wen;
                  addr_d  = i_ARB_ls_addr;
                  wdata_d = i_ARB_ls_wdata;
                  // Loads never carry a byte mask.
                  wmask_d = i_ARB_ls_wen ? i_ARB_ls_wmask : '0;
               end else begin
                  wen_d   = 1'b0;
                  addr_d  = i_ARB_if_addr;
                  wdata_d = '0;
                  wmask_d = '0;
               end
            end
         end
         ISSUE: begin
            if (i_ARB_mem_ready) begin
               mem_valid_d = 1'b0;
               state_d     = WAIT;
            end
         end
         WAIT: begin
            if (i_ARB_mem_rvalid) begin
               state_d     = RESP;
               // Store acknowledgements return zero data.
               rdata_d     = wen_q ? '0 : i_ARB_mem_rdata;
               if_rvalid_d = (owner_q == OWN_IF);
               ls_rvalid_d = (owner_q == OWN_LS);
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge i_ARB_clk or negedge i_ARB_rst_n) begin
      if (!i_ARB_rst_n) begin
         state_q     <= IDLE;
         owner_q     <= OWN_IF;
         last_q      <= OWN_IF;
         wen_q       <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         wmask_q     <= '0;
         mem_valid_q <= 1'b0;
         if_rvalid_q <= 1'b0;
         ls_rvalid_q <= 1'b0;
         rdata_q     <= '0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         last_q      <= last_d;
         wen_q       <= wen_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         wmask_q     <= wmask_d;
         mem_valid_q <= mem_valid_d;
         if_rvalid_q <= if_rvalid_d;
         ls_rvalid_q <= ls_rvalid_d;
         rdata_q     <= rdata_d;
      end
   end

   assign o_ARB_mem_valid = mem_valid_q;
   assign o_ARB_mem_wen   = wen_q;
   assign o_ARB_mem_addr  = addr_q;
   assign o_ARB_mem_wdata = wdata_q;
   assign o_ARB_mem_wmask = wmask_q;
   assign o_ARB_if_rvalid = if_rvalid_q;
   assign o_ARB_ls_rvalid = ls_rvalid_q;
   assign o_ARB_if_rdata  = rdata_q;
   assign o_ARB_ls_rdata  = rdata_q;

endmodule

// File: tb/tb_ysyx_22040386_mem_arb.sv
// Testbench for ysyx_22040386_mem_arb: directed scenarios plus randomized
// traffic against a transaction-level reference model.
module tb_ysyx_22040386_mem_arb;

   localparam int unsigned AW = 64;
   localparam int unsigned DW = 64;
   localparam int unsigned MW = 8;
`ifdef YSYX_22040386_ARB_RR_EN
   localparam bit RR_EN = 1'b1;
`else
   localparam bit RR_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic          if_valid, if_ready, if_rvalid;
   logic [AW-1:0] if_addr;
   logic [DW-1:0] if_rdata;
   logic          ls_valid, ls_wen, ls_ready, ls_rvalid;
   logic [AW-1:0] ls_addr;
   logic [DW-1:0] ls_wdata, ls_rdata;
   logic [MW-1:0] ls_wmask;
   logic          mem_valid, mem_ready, mem_wen, mem_rvalid;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;
   logic [MW-1:0] mem_wmask;

   int n_tests = 0;
   int n_fail  = 0;
   bit last_ls = 1'b0;   // most recent grant went to the LSU

   always #5 clk = ~clk;

   ysyx_22040386_mem_arb dut (
      .i_ARB_clk        (clk),
      .i_ARB_rst_n      (rst_n),
      .i_ARB_if_valid   (if_valid),
      .i_ARB_if_addr    (if_addr),
      .o_ARB_if_ready   (if_ready),
      .o_ARB_if_rvalid  (if_rvalid),
      .o_ARB_if_rdata   (if_rdata),
      .i_ARB_ls_valid   (ls_valid),
      .i_ARB_ls_wen     (ls_wen),
      .i_ARB_ls_addr    (ls_addr),
      .i_ARB_ls_wdata   (ls_wdata),
      .i_ARB_ls_wmask   (ls_wmask),
      .o_ARB_ls_ready   (ls_ready),
      .o_ARB_ls_rvalid  (ls_rvalid),
      .o_ARB_ls_rdata   (ls_rdata),
      .o_ARB_mem_valid  (mem_valid),
      .i_ARB_mem_ready  (mem_ready),
      .o_ARB_mem_wen    (mem_wen),
      .o_ARB_mem_addr   (mem_addr),
      .o_ARB_mem_wdata  (mem_wdata),
      .o_ARB_mem_wmask  (mem_wmask),
      .i_ARB_mem_rvalid (mem_rvalid),
      .i_ARB_mem_rdata  (mem_rdata)
   );

   // Move to the drive point of the next cycle (just after the rising edge).
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Move to the sample point of the current cycle (falling edge).
   task automatic smp();
      @(negedge clk);
   endtask

   task automatic drive_quiet();
      if_valid = 0; if_addr = '0;
      ls_valid = 0; ls_wen = 0; ls_addr = '0; ls_wdata = '0; ls_wmask = '0;
      mem_ready = 0; mem_rvalid = 0; mem_rdata = '0;
   endtask

   task automatic apply_reset();
      drive_quiet();
      rst_n = 0;
      cyc(); cyc();
      rst_n = 1;
      cyc();
      last_ls = 1'b0;
   endtask

   task automatic test_reset();
      logic [269:0] outs;
      drive_quiet();
      rst_n = 0;
      cyc(); cyc(); smp();
      outs = {if_ready, if_rvalid, if_rdata, ls_ready, ls_rvalid, ls_rdata,
              mem_valid, mem_wen, mem_addr, mem_wdata, mem_wmask};
      n_tests++;
      if (outs !== '0) begin n_fail++; $display("FAIL reset_held: got %h want 0", outs); end
      cyc();
      rst_n = 1;
      cyc(); smp();
      outs = {if_ready, if_rvalid, if_rdata, ls_ready, ls_rvalid, ls_rdata,
              mem_valid, mem_wen, mem_addr, mem_wdata, mem_wmask};
      n_tests++;
      if (outs !== '0) begin n_fail++; $display("FAIL reset_released: got %h want 0", outs); end
      cyc();
      last_ls = 1'b0;
   endtask

   task automatic test_if_only();
      if_valid = 1; if_addr = 64'h8000_0000;
      smp();
      n_tests++;
      if ({if_ready, ls_ready} !== 2'b10) begin
         n_fail++; $display("FAIL if_only_ready: got %b want 10", {if_ready, ls_ready});
      end
      cyc();
      if_valid = 0; mem_ready = 1;
      smp();
      n_tests++;
      if ({mem_valid, mem_wen, mem_wmask, mem_addr} !== {1'b1, 1'b0, 8'h00, 64'h8000_0000}) begin
         n_fail++; $display("FAIL if_only_issue: got %b %b %h %h want 1 0 00 80000000",
                            mem_valid, mem_wen, mem_wmask, mem_addr);
      end
      cyc();
      mem_ready = 0; mem_rvalid = 1; mem_rdata = 64'h0000_0013_0000_0413;
      smp();
      n_tests++;
      if ({mem_valid, if_rvalid} !== 2'b00) begin
         n_fail++; $display("FAIL if_only_wait: got %b want 00", {mem_valid, if_rvalid});
      end
      cyc();
      mem_rvalid = 0; mem_rdata = '0;
      smp();
      n_tests++;
      if ({if_rvalid, ls_rvalid} !== 2'b10 || if_rdata !== 64'h0000_0013_0000_0413) begin
         n_fail++; $display("FAIL if_only_resp: got %b %h want 10 0000001300000413",
                            {if_rvalid, ls_rvalid}, if_rdata);
      end
      cyc(); smp();
      n_tests++;
      if ({if_rvalid, ls_rvalid} !== 2'b00) begin
         n_fail++; $display("FAIL if_only_pulse: got %b want 00", {if_rvalid, ls_rvalid});
      end
      cyc();
      last_ls = 1'b0;
   endtask

   task automatic test_store();
      ls_valid = 1; ls_wen = 1; ls_addr = 64'h8000_1004;
      ls_wdata = 64'h0000_0000_DEAD_BEEF; ls_wmask = 8'hF0;
      smp();
      n_tests++;
      if ({if_ready, ls_ready} !== 2'b01) begin
         n_fail++; $display("FAIL store_ready: got %b want 01", {if_ready, ls_ready});
      end
      cyc();
      ls_valid = 0; mem_ready = 1;
      smp();
      n_tests++;
      if ({mem_valid, mem_wen, mem_wmask, mem_addr, mem_wdata} !==
          {1'b1, 1'b1, 8'hF0, 64'h8000_1004, 64'h0000_0000_DEAD_BEEF}) begin
         n_fail++; $display("FAIL store_issue: got %b %b %h %h %h", mem_valid, mem_wen,
                            mem_wmask, mem_addr, mem_wdata);
      end
      cyc();
      mem_ready = 0; mem_rvalid = 1; mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
      smp(); cyc();
      mem_rvalid = 0;
      smp();
      n_tests++;
      if ({ls_rvalid, if_rvalid} !== 2'b10 || ls_rdata !== '0) begin
         n_fail++; $display("FAIL store_ack: got %b %h want 10 0", {ls_rvalid, if_rvalid}, ls_rdata);
      end
      cyc(); smp();
      n_tests++;
      if (ls_rvalid !== 1'b0) begin n_fail++; $display("FAIL store_pulse: got %b want 0", ls_rvalid); end
      cyc();
      last_ls = 1'b1;
   endtask

   task automatic test_backpressure();
      logic [AW-1:0] a;
      logic [DW-1:0] d, r;
      a = {$urandom, $urandom}; d = {$urandom, $urandom}; r = {$urandom, $urandom};
      ls_valid = 1; ls_wen = 0; ls_addr = a; ls_wdata = d; ls_wmask = 8'hFF;
      smp();
      n_tests++;
      if (ls_ready !== 1'b1) begin n_fail++; $display("FAIL bp_accept: got %b want 1", ls_ready); end
      cyc();
      if_valid = 1; if_addr = 64'h8000_0040; mem_ready = 0;
      for (int i = 0; i < 5; i++) begin
         smp();
         n_tests++;
         if ({mem_valid, mem_addr, mem_wdata, mem_wmask, if_ready, ls_ready} !==
             {1'b1, a, d, 8'h00, 2'b00}) begin
            n_fail++; $display("FAIL bp_hold%0d: got %b %h %h %h %b want 1 %h %h 00 00", i,
                               mem_valid, mem_addr, mem_wdata, mem_wmask, {if_ready, ls_ready}, a, d);
         end
         cyc();
      end
      mem_ready = 1;
      smp(); cyc();
      mem_ready = 0; if_valid = 0; ls_valid = 0; mem_rvalid = 1; mem_rdata = r;
      smp(); cyc();
      mem_rvalid = 0;
      smp();
      n_tests++;
      if ({ls_rvalid, if_rvalid} !== 2'b10 || ls_rdata !== r) begin
         n_fail++; $display("FAIL bp_resp: got %b %h want 10 %h", {ls_rvalid, if_rvalid}, ls_rdata, r);
      end
      cyc();
      last_ls = 1'b1;
   endtask

   task automatic test_stray_rvalid();
      drive_quiet();
      for (int i = 0; i < 2; i++) begin
         mem_rvalid = 1; mem_rdata = {$urandom, $urandom};
         smp();
         n_tests++;
         if ({if_rvalid, ls_rvalid, mem_valid} !== 3'b000) begin
            n_fail++; $display("FAIL stray%0d: got %b want 000", i, {if_rvalid, ls_rvalid, mem_valid});
         end
         cyc();
      end
      mem_rvalid = 0; if_valid = 1; if_addr = 64'h8000_0100;
      smp();
      n_tests++;
      if ({if_rvalid, ls_rvalid, if_ready} !== 3'b001) begin
         n_fail++; $display("FAIL stray_idle: got %b want 001", {if_rvalid, ls_rvalid, if_ready});
      end
      cyc();
      if_valid = 0;
   endtask

   task automatic test_reset_in_wait();
      logic [269:0] outs;
      apply_reset();
      if_valid = 1; if_addr = 64'h8000_0200;
      smp(); cyc();
      if_valid = 0; mem_ready = 1;
      smp(); cyc();
      mem_ready = 0; rst_n = 0;
      smp();
      outs = {if_ready, if_rvalid, if_rdata, ls_ready, ls_rvalid, ls_rdata,
              mem_valid, mem_wen, mem_addr, mem_wdata, mem_wmask};
      n_tests++;
      if (outs !== '0) begin n_fail++; $display("FAIL rst_wait_outs: got %h want 0", outs); end
      cyc();
      rst_n = 1; mem_rvalid = 1; mem_rdata = {$urandom, $urandom};
      last_ls = 1'b0;
      smp(); cyc();
      mem_rvalid = 0;
      for (int i = 0; i < 2; i++) begin
         smp();
         n_tests++;
         if ({if_rvalid, ls_rvalid, mem_valid} !== 3'b000) begin
            n_fail++; $display("FAIL rst_wait_resp%0d: got %b want 000", i, {if_rvalid, ls_rvalid, mem_valid});
         end
         cyc();
      end
      ls_valid = 1; ls_wen = 0; ls_addr = 64'h8000_0300;
      smp();
      n_tests++;
      if (ls_ready !== 1'b1) begin n_fail++; $display("FAIL rst_wait_idle: got %b want 1", ls_ready); end
      cyc();
      ls_valid = 0;
   endtask

   task automatic test_tie();
      logic [3:0] got, want;
      int ng;
      apply_reset();
      got = '0; ng = 0;
      if_valid = 1; if_addr = 64'h8000_0400;
      ls_valid = 1; ls_wen = 0; ls_addr = 64'h8000_0800;
      mem_ready = 1; mem_rvalid = 1; mem_rdata = 64'h1234;
      for (int c = 0; c < 40 && ng < 4; c++) begin
         smp();
         if (if_ready || ls_ready) begin
            got[ng] = ls_ready;
            ng++;
         end
         cyc();
      end
      n_tests++;
      if (ng != 4) begin n_fail++; $display("FAIL tie_budget: got %0d grants want 4", ng); end
      want = RR_EN ? 4'b0101 : 4'b1111;
      n_tests++;
      if (got !== want) begin n_fail++; $display("FAIL tie_order: got %b want %b", got, want); end
      drive_quiet();
   endtask

   task automatic test_random();
      int ph, cnt;
      bit if_pend, ls_pend, g_ls, g_if, own_ls, e_wen;
      logic [AW-1:0] e_addr;
      logic [DW-1:0] e_wdata, e_rdata;
      logic [MW-1:0] e_wmask;
      apply_reset();
      ph = 0; cnt = 0; if_pend = 0; ls_pend = 0; own_ls = 0; e_wen = 0;
      e_addr = '0; e_wdata = '0; e_rdata = '0; e_wmask = '0;
      for (int c = 0; c < 4000; c++) begin
         if (!if_pend && $urandom_range(0, 2) == 0) begin
            if_pend = 1; if_addr = {$urandom, $urandom};
         end
         if_valid = if_pend;
         if (!ls_pend && $urandom_range(0, 2) == 0) begin
            ls_pend = 1; ls_wen = 1'($urandom_range(0, 1));
            ls_addr = {$urandom, $urandom}; ls_wdata = {$urandom, $urandom};
            ls_wmask = 8'($urandom);
         end
         ls_valid = ls_pend;
         mem_ready = 1'($urandom_range(0, 1));
         mem_rdata = {$urandom, $urandom};
         if (ph == 2) begin
            mem_rvalid = (cnt == 0);
            if (cnt > 0) cnt--;
         end else begin
            mem_rvalid = ($urandom_range(0, 7) == 0);
         end
         smp();
         case (ph)
            0: begin
               g_ls = ls_pend && (!if_pend || (RR_EN ? !last_ls : 1'b1));
               g_if = if_pend && !g_ls;
               n_tests++;
               if ({if_ready, ls_ready, mem_valid, if_rvalid, ls_rvalid} !== {g_if, g_ls, 3'b000}) begin
                  n_fail++; $display("FAIL rnd_grant c%0d: got %b want %b", c,
                                     {if_ready, ls_ready, mem_valid, if_rvalid, ls_rvalid}, {g_if, g_ls, 3'b000});
               end
               if (g_if || g_ls) begin
                  own_ls  = g_ls;
                  e_wen   = g_ls ? ls_wen : 1'b0;
                  e_addr  = g_ls ? ls_addr : if_addr;
                  e_wdata = ls_wdata;
                  e_wmask = (g_ls && ls_wen) ? ls_wmask : 8'h00;
                  last_ls = g_ls;
                  if (g_ls) ls_pend = 0; else if_pend = 0;
                  ph = 1;
               end
            end
            1: begin
               n_tests++;
               if ({mem_valid, mem_wen, mem_addr, mem_wmask, if_ready, ls_ready, if_rvalid, ls_rvalid} !==
                   {1'b1, e_wen, e_addr, e_wmask, 4'b0000} || (own_ls && mem_wdata !== e_wdata)) begin
                  n_fail++; $display("FAIL rnd_issue c%0d: got %b %b %h %h %h want 1 %b %h %h %h", c,
                                     mem_valid, mem_wen, mem_addr, mem_wmask, mem_wdata,
                                     e_wen, e_addr, e_wmask, e_wdata);
               end
               if (mem_ready) begin ph = 2; cnt = $urandom_range(0, 3); end
            end
            2: begin
               n_tests++;
               if ({mem_valid, if_ready, ls_ready, if_rvalid, ls_rvalid} !== 5'b00000) begin
                  n_fail++; $display("FAIL rnd_wait c%0d: got %b want 00000", c,
                                     {mem_valid, if_ready, ls_ready, if_rvalid, ls_rvalid});
               end
               if (mem_rvalid) begin
                  e_rdata = e_wen ? '0 : mem_rdata;
                  ph = 3;
               end
            end
            default: begin
               n_tests++;
               if ({if_rvalid, ls_rvalid, mem_valid, if_ready, ls_ready} !== {!own_ls, own_ls, 3'b000} ||
                   (own_ls ? ls_rdata : if_rdata) !== e_rdata) begin
                  n_fail++; $display("FAIL rnd_resp c%0d: got %b %h want %b %h", c,
                                     {if_rvalid, ls_rvalid, mem_valid, if_ready, ls_ready},
                                     own_ls ? ls_rdata : if_rdata, {!own_ls, own_ls, 3'b000}, e_rdata);
               end
               ph = 0;
            end
         endcase
         cyc();
      end
      drive_quiet();
   endtask

   initial begin
      rst_n = 0;
      drive_quiet();
      #1;
      test_reset();
      test_if_only();
      test_store();
      test_backpressure();
      test_stray_rvalid();
      test_reset_in_wait();
      test_tie();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
